// File: rtl/tfcall_sched.sv
// Round-robin scheduler sharing one registered function unit (SUM, DOUBLE, NO_ARGS)
// between NREQ requesters; each call is granted, executed once and acknowledged by index.
module tfcall_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op,
    input  logic [WIDTH*NREQ-1:0]   arg_a,
    input  logic [WIDTH*NREQ-1:0]   arg_b,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        result,
    output logic [IDW-1:0]          result_id,
    output logic                    err,
    output logic                    busy,
    output logic [15:0]             calls_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALL = 2'd1,
        S_RET  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SUM = 2'b00;
    localparam logic [1:0] OP_DBL = 2'b01;
    localparam logic [1:0] OP_NOA = 2'b10;

    // Returns {err, result} for one call.
    function automatic logic [WIDTH:0] eval_call(input logic [1:0] f,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        case (f)
            OP_SUM:  r = {1'b0, a + b};
            OP_DBL:  r = {1'b0, a[WIDTH-2:0], 1'b0};
            OP_NOA:  r = {1'b0, WIDTH'(1)};
            default: r = {1'b1, {WIDTH{1'b0}}};
        endcase
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     id_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [NREQ-1:0]    ack_q;
    logic [WIDTH-1:0]   result_q;
    logic [IDW-1:0]     result_id_q;
    logic               err_q;
    logic               busy_q;
    logic [15:0]        calls_done_q;

    logic [NREQ-1:0]    req_m_s;
    logic [IDW-1:0]     win_s;
    logic               any_s;
    logic               grant_s;
    logic [IDW-1:0]     next_ptr_s;
    logic [WIDTH:0]     eval_s;
    int                 idx;

    // Round-robin pick starting at ptr_q; in RET the requester just served is masked out.
    always_comb begin
        req_m_s = (state_q == S_RET) ? (req & ~(NREQ'(1) << id_q)) : req;
        win_s   = '0;
        any_s   = 1'b0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx   = (int'(ptr_q) + k) % NREQ;
            win_s = req_m_s[idx] ? IDW'(idx) : win_s;
            any_s = any_s | req_m_s[idx];
        end
        next_ptr_s = (win_s == IDW'(NREQ - 1)) ? '0 : win_s + IDW'(1);
        eval_s     = eval_call(op_q, a_q, b_q);
    end

    // Next-state logic for the IDLE/CALL/RET controller.
    always_comb begin
        state_d = state_q;
        grant_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_s) begin
                    state_d = S_CALL;
                    grant_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALL: state_d = S_RET;
            S_RET: begin
                if (any_s) begin
                    state_d = S_CALL;
                    grant_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, argument latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            op_q         <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            ack_q        <= '0;
            result_q     <= '0;
            result_id_q  <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            calls_done_q <= 16'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            ack_q   <= '0;
            err_q   <= 1'b0;
            if (grant_s) begin
                id_q  <= win_s;
                op_q  <= op[2*int'(win_s) +: 2];
                a_q   <= arg_a[WIDTH*int'(win_s) +: WIDTH];
                b_q   <= arg_b[WIDTH*int'(win_s) +: WIDTH];
                ptr_q <= next_ptr_s;
            end
            // Leaving CALL: publish the result so ack is high for the whole RET cycle.
            if (state_q == S_CALL) begin
                result_q     <= eval_s[WIDTH-1:0];
                err_q        <= eval_s[WIDTH];
                ack_q        <= NREQ'(1) << id_q;
                result_id_q  <= id_q;
                calls_done_q <= calls_done_q + 16'd1;
            end
        end
    end

    assign ack        = ack_q;
    assign result     = result_q;
    assign result_id  = result_id_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign calls_done = calls_done_q;

endmodule

// File: doc/tfcall_sched.md
# tfcall_sched

Round-robin scheduler that shares one registered function unit (8-bit `sum`, `double`, `no_args` constant) between up to four requesters. Each requester issues a call with an opcode and two operands. The scheduler grants one call at a time, latches its arguments, evaluates it in a single execute cycle and returns the result with a one-cycle acknowledge tagged by requester index. It sits between the small arithmetic callers and the single shared evaluation datapath.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: operand and result width.
- `IDW`, 2: requester index width, equal to clog2(NREQ).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester call request, held until its `ack`.
- `op`  in  2*NREQ  packed opcode per requester (slice i = bits 2i+1:2i): 00 SUM, 01 DOUBLE, 10 NO_ARGS, 11 illegal.
- `arg_a`  in  WIDTH*NREQ  packed first argument per requester.
- `arg_b`  in  WIDTH*NREQ  packed second argument per requester (used by SUM only).
- `ack`  out  NREQ  one-hot, one-cycle completion pulse.
- `result`  out  WIDTH  return value; valid while any `ack` bit is high.
- `result_id`  out  IDW  index of the completing requester.
- `err`  out  1  high with `ack` when the call used the illegal opcode.
- `busy`  out  1  high in CALL and RET.
- `calls_done`  out  16  count of completed calls, wraps 0xFFFF -> 0.

## Operation
- FSM states: IDLE, CALL, RET.
  - IDLE: if any `req` is set, select a winner round-robin, latch its `op`/`arg_a`/`arg_b` and index, then go to CALL. Otherwise stay in IDLE.
  - CALL: evaluate the latched call into the result register, then go to RET.
  - RET: `ack[id]`, `result`, `result_id` and `err` are valid. On the next edge, select a new winner from `req` with the just-served bit masked. If one exists, latch it and go to CALL; otherwise go to IDLE.
- Round-robin: priority starts at index ptr and wraps. After each grant to i, ptr = (i+1) mod NREQ.
- Arithmetic, all truncated to WIDTH bits:
  - SUM = (a + b) mod 2^WIDTH.
  - DOUBLE = (a << 1) mod 2^WIDTH.
  - NO_ARGS = 1; the arguments are ignored.
  - Illegal opcode: result = 0 and err = 1.
- Arguments are captured at grant. Argument changes after grant, or `req` dropping after grant, do not affect the call, and `ack` still pulses.
- `calls_done` increments once per `ack` pulse, including err calls.
- Reset values: state IDLE, ptr 0, `ack` 0, `result` 0, `result_id` 0, `err` 0, `busy` 0, `calls_done` 0.
- Reset asserted in CALL or RET aborts the call: no `ack` is issued, and all outputs take their reset values on that edge.
- `ack`, `err` and `result` are registered and change only on `clk` edges. No output has a combinational path from any input.

## Timing
- Latency: `req` sampled high in IDLE at edge E gives CALL after E, RET after E+1, and `ack` high for exactly the cycle after E+1.
- Back-to-back: with continuous requests the scheduler alternates CALL and RET, giving one `ack` every 2 cycles.
- The requester must deassert `req` in the cycle after `ack`, or hold it to issue a new call. The masking in RET prevents the same requester being re-granted on the edge that ends its `ack` cycle.
- If only the just-served requester is still requesting in RET, the FSM goes to IDLE. A requester that keeps `req` asserted is therefore re-granted from IDLE one edge later: one `ack` per 3 cycles.
- `err` and `result_id` are valid only while `ack` is nonzero. Otherwise `err` = 0, and `result` and `result_id` hold their last values.

## Test plan
- Single SUM: reset, then `req[0]`=1, op 00, a=1, b=2 -> `ack[0]` pulses two edges later with `result`=3, `result_id`=0, `err`=0, and `calls_done`=1.
- Wrap and DOUBLE:
  - SUM 200+100 -> `result`=44.
  - DOUBLE a=0x90 -> `result`=0x20.
  - NO_ARGS with a=0xFF -> `result`=1.
- Contention: all four requesters raise `req` in the same cycle with distinct ops -> acks in order 0,1,2,3, spaced 2 cycles, each with the correct result. `busy` stays high until the final RET completes.
- Fairness: `req[0]` and `req[2]` held continuously -> grants alternate 0,2,0,2. Neither requester is granted twice in a row.
- Illegal opcode on requester 3 -> `ack[3]` with `err`=1, `result`=0, and `calls_done` incremented. Arguments changed after grant do not alter `result`.
- Reset mid-call: assert `rst` for one cycle while in CALL -> no `ack` appears, all outputs return to reset values, and the next request is granted to the lowest index first (ptr=0).
